// File: rtl/int_txn_engine_if.sv
// Memory-side burst bus between the transaction engine (master) and external memory (slave).
// Read-address, read-data, write-address, write-data and write-response channels.
interface int_txn_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  arValid;
    logic                  arReady;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  rValid;
    logic                  rReady;
    logic [DATA_WIDTH-1:0] rData;
    logic [1:0]            rResp;
    logic                  rLast;
    logic                  awValid;
    logic                  awReady;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  wValid;
    logic                  wReady;
    logic [DATA_WIDTH-1:0] wData;
    logic                  wLast;
    logic                  bValid;
    logic                  bReady;
    logic [1:0]            bResp;

    modport master (
        output arValid, araddr, arlen, rReady, awValid, awaddr, awlen, wValid, wData, wLast, bReady,
        input  arReady, rValid, rData, rResp, rLast, awReady, wReady, bValid, bResp
    );
    modport slave (
        input  arValid, araddr, arlen, rReady, awValid, awaddr, awlen, wValid, wData, wLast, bReady,
        output arReady, rValid, rData, rResp, rLast, awReady, wReady, bValid, bResp
    );
endinterface

// File: rtl/int_txn_engine.sv
// CU->INT transaction responder: independent read (memory->cache) and write (cache->memory) burst engines
// sharing one sticky ERROR flag.
module int_txn_engine #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 64,
    parameter  int BURST_LEN  = 16,
    localparam int CW         = $clog2(BURST_LEN)
) (
    input  logic                  i_SYSTEM_clk,
    input  logic                  i_SYSTEM_rst,
    input  logic                  i_CU_INT_initReadTx,
    input  logic                  i_CU_INT_initWriteTx,
    input  logic [ADDR_WIDTH-1:0] i_ExMU_readAddr,
    input  logic [ADDR_WIDTH-1:0] i_ExMU_writeAddr,
    output logic                  o_INT_readTxnDone,
    output logic                  o_INT_writeTxnDone,
    output logic                  o_INT_cacheWrEn,
    output logic [CW-1:0]         o_INT_cacheWrAddr,
    output logic [DATA_WIDTH-1:0] o_INT_cacheWrData,
    output logic                  o_INT_cacheRdEn,
    output logic [CW-1:0]         o_INT_cacheRdAddr,
    input  logic [DATA_WIDTH-1:0] i_ExMU_cacheRdData,
    int_txn_engine_if.master      mem,
    output logic [31:0]           o_status
);
    typedef enum logic [2:0] {R_IDLE = 3'd0, R_ADDR = 3'd1, R_DATA = 3'd2} rstate_e;
    typedef enum logic [2:0] {W_IDLE = 3'd0, W_ADDR = 3'd1, W_DATA = 3'd2, W_RESP = 3'd3} wstate_e;

    localparam logic [CW-1:0] LAST_IDX  = CW'(BURST_LEN - 1);
    localparam logic [CW:0]   BURST_CNT = (CW + 1)'(BURST_LEN);
    localparam logic [7:0]    AXLEN     = 8'(BURST_LEN - 1);

    rstate_e                        rstate_q, rstate_d;
    wstate_e                        wstate_q, wstate_d;
    logic                           err_q, err_d;
    logic                           ovr_q, ovr_d;
    logic [ADDR_WIDTH-1:0]          raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0]          waddr_q, waddr_d;
    logic [CW-1:0]                  rcnt_q, rcnt_d;
    logic [CW-1:0]                  wcnt_q, wcnt_d;
    logic [CW:0]                    issued_q, issued_d;
    logic                           inflight_q, inflight_d;
    logic [1:0][DATA_WIDTH-1:0]     fifo_q, fifo_d;
    logic                           wptr_q, wptr_d;
    logic                           rptr_q, rptr_d;
    logic [1:0]                     fcnt_q, fcnt_d;
    logic                           r_fault, w_fault;
    logic                           w_push, w_pop;

    // Read engine: a faulty beat is not written to the cache.
    always_comb begin
        rstate_d          = rstate_q;
        raddr_d           = raddr_q;
        rcnt_d            = rcnt_q;
        r_fault           = 1'b0;
        o_INT_cacheWrEn   = 1'b0;
        o_INT_cacheWrAddr = rcnt_q;
        o_INT_cacheWrData = mem.rData;
        mem.arValid       = 1'b0;
        mem.araddr        = raddr_q;
        mem.arlen         = AXLEN;
        mem.rReady        = err_q;
        if (!err_q) begin
            case (rstate_q)
                R_IDLE: begin
                    r_fault = mem.rValid;
                    if (i_CU_INT_initReadTx) begin
                        rstate_d = R_ADDR;
                        raddr_d  = i_ExMU_readAddr;
                        rcnt_d   = '0;
                    end
                end
                R_ADDR: begin
                    r_fault     = mem.rValid;
                    mem.arValid = 1'b1;
                    if (mem.arReady) rstate_d = R_DATA;
                end
                R_DATA: begin
                    mem.rReady = 1'b1;
                    if (mem.rValid) begin
                        r_fault         = (mem.rResp != 2'b00) || (mem.rLast != (rcnt_q == LAST_IDX));
                        o_INT_cacheWrEn = !r_fault;
                        rcnt_d          = rcnt_q + 1'b1;
                        if (rcnt_q == LAST_IDX) rstate_d = R_IDLE;
                    end
                end
                default: rstate_d = R_IDLE;
            endcase
        end
    end

    // Write engine: cache reads are prefetched into a 2-entry FIFO, never more than it can absorb.
    always_comb begin
        wstate_d          = wstate_q;
        waddr_d           = waddr_q;
        wcnt_d            = wcnt_q;
        issued_d          = issued_q;
        fifo_d            = fifo_q;
        wptr_d            = wptr_q;
        rptr_d            = rptr_q;
        w_fault           = 1'b0;
        w_push            = inflight_q;
        w_pop             = 1'b0;
        o_INT_cacheRdEn   = 1'b0;
        o_INT_cacheRdAddr = issued_q[CW-1:0];
        mem.awValid       = 1'b0;
        mem.awaddr        = waddr_q;
        mem.awlen         = AXLEN;
        mem.wValid        = 1'b0;
        mem.wData         = fifo_q[rptr_q];
        mem.wLast         = (wcnt_q == LAST_IDX);
        mem.bReady        = err_q;
        if (!err_q) begin
            case (wstate_q)
                W_IDLE: begin
                    if (i_CU_INT_initWriteTx) begin
                        wstate_d = W_ADDR;
                        waddr_d  = i_ExMU_writeAddr;
                        wcnt_d   = '0;
                        issued_d = '0;
                    end
                end
                W_ADDR: begin
                    mem.awValid = 1'b1;
                    if (mem.awReady) wstate_d = W_DATA;
                end
                W_DATA: begin
                    mem.wValid = (fcnt_q != 2'd0);
                    if (mem.wValid && mem.wReady) begin
                        w_pop  = 1'b1;
                        wcnt_d = wcnt_q + 1'b1;
                        if (wcnt_q == LAST_IDX) wstate_d = W_RESP;
                    end
                end
                W_RESP: begin
                    mem.bReady = 1'b1;
                    if (mem.bValid) begin
                        w_fault  = (mem.bResp != 2'b00);
                        wstate_d = W_IDLE;
                    end
                end
                default: wstate_d = W_IDLE;
            endcase
            o_INT_cacheRdEn = ((wstate_q == W_ADDR) || (wstate_q == W_DATA)) &&
                              (({1'b0, fcnt_q} + {2'b00, inflight_q}) < 3'd2) &&
                              (issued_q < BURST_CNT);
            if (o_INT_cacheRdEn) issued_d = issued_q + 1'b1;
        end
        if (w_push) begin
            fifo_d[wptr_q] = i_ExMU_cacheRdData;
            wptr_d         = ~wptr_q;
        end
        if (w_pop) rptr_d = ~rptr_q;
        fcnt_d = fcnt_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    always_comb begin
        inflight_d = o_INT_cacheRdEn;
        err_d      = err_q | r_fault | w_fault;
        ovr_d      = ovr_q | (!err_q && ((i_CU_INT_initReadTx && rstate_q != R_IDLE) ||
                                          (i_CU_INT_initWriteTx && wstate_q != W_IDLE)));
    end

    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            rstate_q   <= R_IDLE;
            wstate_q   <= W_IDLE;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            rcnt_q     <= '0;
            wcnt_q     <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            fifo_q     <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            rstate_q   <= rstate_d;
            wstate_q   <= wstate_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            rcnt_q     <= rcnt_d;
            wcnt_q     <= wcnt_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign o_INT_readTxnDone  = !err_q && (rstate_q == R_IDLE);
    assign o_INT_writeTxnDone = !err_q && (wstate_q == W_IDLE);
    assign o_status = err_q ? 32'hFFFF_FFFF
                            : {23'd0, ovr_q, 1'b0, wstate_q, 1'b0, rstate_q};
endmodule
